// File: rtl/cordic_pkg.sv
// Shared CORDIC control constants: FSM state encoding, default iteration count
// and the hyperbolic repeat indices used by both controller and datapath.
package cordic_pkg;

  localparam int unsigned ITER_MAX_DEF = 24;
  localparam int unsigned ADRS_W_DEF   = 5;

  // Hyperbolic CORDIC must repeat these iterations to converge
  localparam int unsigned REP_IDX_A = 4;
  localparam int unsigned REP_IDX_B = 13;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_INIT   = 3'd1,
    S_FETCH  = 3'd2,
    S_UPDATE = 3'd3,
    S_DONE   = 3'd4
  } state_t;

endpackage

// File: rtl/cordic_iter_cnt.sv
// Iteration index k with hyperbolic repeat tracking and last-iteration detect.
module cordic_iter_cnt
  import cordic_pkg::*;
#(
  parameter int unsigned ITER_MAX = ITER_MAX_DEF,
  parameter int unsigned ADRS_W   = ADRS_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              load_mode,
  input  logic              adv,
  input  logic              mode,
  output logic [ADRS_W-1:0] k,
  output logic              last_c
);

  logic rep_flag;
  logic rep_due;

  assign rep_due = mode && !rep_flag &&
                   ((k == ADRS_W'(REP_IDX_A)) || (k == ADRS_W'(REP_IDX_B)));
  assign last_c  = (k == ADRS_W'(ITER_MAX - 1)) && !rep_due;

  // k stays put after the final update so ADRS reflects it while in DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k        <= '0;
      rep_flag <= 1'b0;
    end else if (load) begin
      k        <= load_mode ? ADRS_W'(1) : '0;
      rep_flag <= 1'b0;
    end else if (adv && !last_c) begin
      if (rep_due) begin
        rep_flag <= 1'b1;
      end else begin
        k        <= k + ADRS_W'(1);
        rep_flag <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/cordic_iter_ctrl.sv
// CORDIC iteration sequencer: init load, ROM fetch / datapath update per
// iteration, then hold the result until the consumer acknowledges.
module cordic_iter_ctrl
  import cordic_pkg::*;
#(
  parameter int unsigned ITER_MAX = ITER_MAX_DEF,
  parameter int unsigned ADRS_W   = ADRS_W_DEF
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              BEG_FSM,
  input  logic              MODE,
  input  logic              ACK,
  output logic              EN_ROM1,
  output logic [ADRS_W-1:0] ADRS,
  output logic              LOAD_INIT,
  output logic              EN_ITER,
  output logic [ADRS_W-1:0] SHIFT,
  output logic              BUSY,
  output logic              RDY
);

  state_t            state_q;
  state_t            state_d;
  logic              mode_r;
  logic              start;
  logic              adv;
  logic              last_c;
  logic [ADRS_W-1:0] k;

  cordic_iter_cnt #(
    .ITER_MAX (ITER_MAX),
    .ADRS_W   (ADRS_W)
  ) u_cnt (
    .clk       (CLK),
    .rst_n     (RST),
    .load      (start),
    .load_mode (MODE),
    .adv       (adv),
    .mode      (mode_r),
    .k         (k),
    .last_c    (last_c)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= S_IDLE;
      mode_r  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start) mode_r <= MODE;
    end
  end

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    adv     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (BEG_FSM) begin
          start   = 1'b1;
          state_d = S_INIT;
        end
      end
      S_INIT:   state_d = S_FETCH;
      S_FETCH:  state_d = S_UPDATE;
      S_UPDATE: begin
        adv     = 1'b1;
        state_d = last_c ? S_DONE : S_FETCH;
      end
      S_DONE: begin
        if (ACK) state_d = S_IDLE;
      end
      default:  state_d = S_IDLE;
    endcase
  end

  // Moore outputs; reset drives state to IDLE and k to 0, so all read 0
  always_comb begin
    EN_ROM1   = 1'b0;
    LOAD_INIT = 1'b0;
    EN_ITER   = 1'b0;
    BUSY      = 1'b0;
    RDY       = 1'b0;
    ADRS      = k;
    SHIFT     = k;
    case (state_q)
      S_INIT: begin
        LOAD_INIT = 1'b1;
        BUSY      = 1'b1;
      end
      S_FETCH: begin
        EN_ROM1 = 1'b1;
        BUSY    = 1'b1;
      end
      S_UPDATE: begin
        EN_ITER = 1'b1;
        BUSY    = 1'b1;
      end
      S_DONE:  RDY = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: doc/cordic_iter_ctrl.md
CORDIC_ITER_CTRL -- requirements
Module: cordic_iter_ctrl

Interface
REQ-001 Parameter ITER_MAX, default 24, sets the number of base iterations, with a legal range of 2..31.
REQ-002 Parameter ADRS_W, default 5, sets the arctangent ROM address width.
REQ-003 CLK  input  1  is the system clock, with all state on the rising edge.
REQ-004 RST  input  1  is the reset, asynchronous and active-low.
REQ-005 BEG_FSM  input  1  is the start request, sampled only in IDLE.
REQ-006 MODE  input  1  selects the rotation type: 0 = circular, 1 = hyperbolic; it is latched together with BEG_FSM.
REQ-007 ACK  input  1  indicates the consumer has taken the result, and releases RDY.
REQ-008 EN_ROM1  output  1  is the read enable to the downstream angle ROM.
REQ-009 ADRS  output  ADRS_W  is the ROM address, equal to the current iteration index k.
REQ-010 LOAD_INIT  output  1  is a one-cycle pulse that loads the initial X/Y/Z into the datapath.
REQ-011 EN_ITER  output  1  is the datapath update enable; ROM data O_D is valid during this cycle.
REQ-012 SHIFT  output  ADRS_W  is the shift amount for the current update, equal to k.
REQ-013 BUSY  output  1  is high in every state except IDLE and DONE.
REQ-014 RDY  output  1  indicates the result is valid, and is held until ACK.

Function
REQ-015 The FSM SHALL have states IDLE, INIT, FETCH, UPDATE and DONE, with Moore outputs decoded from the state and k registers only.
REQ-016 IDLE SHALL move to INIT when BEG_FSM=1; on that edge the FSM latches MODE into mode_r, loads k to 1 if hyperbolic or 0 if circular, and clears rep_flag.
REQ-017 INIT SHALL assert LOAD_INIT for exactly one cycle, then move to FETCH.
REQ-018 FETCH SHALL assert EN_ROM1=1 with ADRS=k, then move to UPDATE; the ROM is registered, giving a one-cycle read latency.
REQ-019 UPDATE SHALL assert EN_ITER=1 with SHIFT=k, and hold ADRS=k.
REQ-020 In circular mode, after UPDATE, k SHALL advance to k+1.
REQ-021 In hyperbolic mode, when k is 4 or 13 and rep_flag=0, k SHALL be held and rep_flag set; otherwise k advances to k+1 and rep_flag is cleared.
REQ-022 The last update SHALL be k=ITER_MAX-1 with no repeat pending; UPDATE then moves to DONE, and otherwise returns to FETCH.
REQ-023 The update count U SHALL equal ITER_MAX in circular mode, and ITER_MAX-1 plus the number of values {4,13} below ITER_MAX in hyperbolic mode; at defaults this gives 24 circular and 25 hyperbolic.
REQ-024 RDY SHALL first go high 2U+2 cycles after the edge that samples BEG_FSM, giving 50 circular and 52 hyperbolic at defaults.
REQ-025 DONE SHALL hold RDY=1 and BUSY=0, then move to IDLE on the edge where ACK=1; RDY is low in the following cycle.
REQ-026 ACK arriving on the first DONE cycle SHALL be honoured, so RDY is high for exactly one cycle.
REQ-027 BEG_FSM SHALL be ignored outside IDLE, including when it coincides with ACK in DONE; a new start requires BEG_FSM to be sampled in IDLE.
REQ-028 MODE changes while BUSY=1 SHALL have no effect on the current operation.
REQ-029 ACK outside DONE SHALL be ignored.
REQ-030 ADRS SHALL hold the last k in DONE, and hold the value loaded at start in INIT.

Reset
REQ-031 RST=0 SHALL immediately force IDLE, at any point including mid-operation.
REQ-032 During reset, every output SHALL be forced to 0: ADRS=0, SHIFT=0, EN_ROM1=0, EN_ITER=0, LOAD_INIT=0, BUSY=0 and RDY=0.
REQ-033 During reset, k and rep_flag SHALL be cleared to 0.
REQ-034 Reset release SHALL NOT start an operation until BEG_FSM is sampled in IDLE.

Structure
REQ-035 Package cordic_pkg SHALL hold the state encoding, the ITER_MAX default and the repeat-index constants 4 and 13, shared with the datapath.
REQ-036 A single sub-module, cordic_iter_cnt, SHALL implement k, rep_flag, the advance rule and the last-iteration flag; everything else is flat.

Verification
REQ-037 Circular start: MODE=0, BEG_FSM pulse -> LOAD_INIT once, then 24 EN_ROM1/EN_ITER pairs with ADRS 0..23, and RDY at cycle 50.
REQ-038 Hyperbolic start: MODE=1 -> the SHIFT sequence is 1,2,3,4,4,5,...,13,13,...,23, giving 25 EN_ITER pulses, and RDY at cycle 52.
REQ-039 Handshake: hold ACK low for 10 cycles after RDY -> RDY stays high; an ACK pulse -> IDLE next cycle with RDY=0.
REQ-040 Reset mid-run: drop RST at k=7 in FETCH -> all outputs go to 0 asynchronously; after release, a new BEG_FSM restarts from k=0.
REQ-041 Ignored inputs: BEG_FSM pulsed at k=10 and MODE toggled during the run -> the sequence is unchanged; BEG_FSM together with ACK in DONE -> IDLE with no restart.
REQ-042 Boundary: ITER_MAX=5 in hyperbolic mode -> SHIFT sequence 1,2,3,4,4 with U=5, and RDY at cycle 12.
